// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, 32-step restoring
// divider for DIV/DIVU with pipeline stall, and MFHI/MFLO read mux.

module hilo_muldiv_unit_chk (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  input logic        stall,
  input logic [1:0]  state,
  input logic [5:0]  cnt
);

  a_state_legal: assert property (@(posedge clk) disable iff (rst) state != 2'd3);
  a_cnt_range:   assert property (@(posedge clk) disable iff (rst) (state == 2'd1) |-> (cnt <= 6'd31));
  a_flush_stall: assert property (@(posedge clk) disable iff (rst) flush |-> !stall);
  a_done_nostall: assert property (@(posedge clk) disable iff (rst) (state == 2'd2) |-> !stall);

endmodule

module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [7:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    if (x[31]) begin
      return neg32(x);
    end else begin
      return x;
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [5:0]  cnt_r, cnt_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic [31:0] rem_r, rem_nxt_s;
  logic [31:0] quo_r, quo_nxt_s;
  logic [31:0] dvsr_r, dvsr_nxt_s;
  logic [31:0] dvnd_raw_r, dvnd_raw_nxt_s;
  logic        quo_neg_r, quo_neg_nxt_s;
  logic        rem_neg_r, rem_neg_nxt_s;
  logic        dbz_r, dbz_nxt_s;

  logic        div_sel_s, divu_sel_s, mult_sel_s, multu_sel_s, mthi_sel_s, mtlo_sel_s;
  logic [63:0] smul_s, umul_s;
  logic [32:0] rem_sh_s;
  logic [33:0] trial_s;
  logic        trial_ok_s;
  logic [31:0] lo_div_s, hi_div_s;

  // Priority decode: DIV > DIVU > MULT > MULTU > MTHI > MTLO
  always_comb begin
    div_sel_s   = op[5];
    divu_sel_s  = ~op[5] & op[4];
    mult_sel_s  = ~op[5] & ~op[4] & op[7];
    multu_sel_s = ~op[5] & ~op[4] & ~op[7] & op[6];
    mthi_sel_s  = ~op[5] & ~op[4] & ~op[7] & ~op[6] & op[1];
    mtlo_sel_s  = ~op[5] & ~op[4] & ~op[7] & ~op[6] & ~op[1] & op[0];
  end

  // Products computed at 64 bits with explicit sign/zero extension
  always_comb begin
    smul_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    umul_s = {32'd0, src_a} * {32'd0, src_b};
  end

  // One restoring step on {rem, quo}; quo initially holds the dividend magnitude
  always_comb begin
    rem_sh_s   = {rem_r, quo_r[31]};
    trial_s    = {1'b0, rem_sh_s} - {2'b00, dvsr_r};
    trial_ok_s = ~trial_s[33];
    lo_div_s   = quo_neg_r ? neg32(quo_r) : quo_r;
    hi_div_s   = rem_neg_r ? neg32(rem_r) : rem_r;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    hi_nxt_s       = hi_r;
    lo_nxt_s       = lo_r;
    rem_nxt_s      = rem_r;
    quo_nxt_s      = quo_r;
    dvsr_nxt_s     = dvsr_r;
    dvnd_raw_nxt_s = dvnd_raw_r;
    quo_neg_nxt_s  = quo_neg_r;
    rem_neg_nxt_s  = rem_neg_r;
    dbz_nxt_s      = dbz_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!ex_valid) begin
            state_nxt_s = ST_IDLE;
          end else if (div_sel_s | divu_sel_s) begin
            dvnd_raw_nxt_s = src_a;
            quo_nxt_s      = div_sel_s ? abs32(src_a) : src_a;
            dvsr_nxt_s     = div_sel_s ? abs32(src_b) : src_b;
            rem_nxt_s      = 32'd0;
            quo_neg_nxt_s  = div_sel_s & (src_a[31] ^ src_b[31]);
            rem_neg_nxt_s  = div_sel_s & src_a[31];
            dbz_nxt_s      = (src_b == 32'd0);
            cnt_nxt_s      = 6'd0;
            state_nxt_s    = ST_RUN;
          end else if (mult_sel_s) begin
            {hi_nxt_s, lo_nxt_s} = smul_s;
          end else if (multu_sel_s) begin
            {hi_nxt_s, lo_nxt_s} = umul_s;
          end else if (mthi_sel_s) begin
            hi_nxt_s = src_a;
          end else if (mtlo_sel_s) begin
            lo_nxt_s = src_a;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_nxt_s = trial_ok_s ? trial_s[31:0] : rem_sh_s[31:0];
          quo_nxt_s = {quo_r[30:0], trial_ok_s};
          cnt_nxt_s = cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          if (dbz_r) begin
            hi_nxt_s = dvnd_raw_r;
            lo_nxt_s = 32'hFFFF_FFFF;
          end else begin
            hi_nxt_s = hi_div_s;
            lo_nxt_s = lo_div_s;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 6'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      dvsr_r     <= 32'd0;
      dvnd_raw_r <= 32'd0;
      quo_neg_r  <= 1'b0;
      rem_neg_r  <= 1'b0;
      dbz_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      hi_r       <= hi_nxt_s;
      lo_r       <= lo_nxt_s;
      rem_r      <= rem_nxt_s;
      quo_r      <= quo_nxt_s;
      dvsr_r     <= dvsr_nxt_s;
      dvnd_raw_r <= dvnd_raw_nxt_s;
      quo_neg_r  <= quo_neg_nxt_s;
      rem_neg_r  <= rem_neg_nxt_s;
      dbz_r      <= dbz_nxt_s;
    end
  end

  // Stall and read mux stay combinational so flush and MFHI/MFLO act in-cycle
  always_comb begin
    stall = ~rst & ~flush &
            (((state_r == ST_IDLE) & ex_valid & (op[5] | op[4])) | (state_r == ST_RUN));
    if (op[3]) begin
      hilo_rdata = hi_r;
    end else if (op[2]) begin
      hilo_rdata = lo_r;
    end else begin
      hilo_rdata = 32'd0;
    end
    hi = hi_r;
    lo = lo_r;
  end

  hilo_muldiv_unit_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .state (state_r),
    .cnt   (cnt_r)
  );

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, flush/reset
// sequences, and randomized operations against an arithmetic reference model.

module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] hilo_rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stalls;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Architectural reference: plain arithmetic on the whole operands
  function automatic void ref_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l, output bit is_div);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    is_div = 1'b0;
    if (o[5] || o[4]) begin
      is_div = 1'b1;
      if (b == 32'd0) begin
        h = a;
        l = 32'hFFFF_FFFF;
      end else if (o[5]) begin
        l = 32'(sa / sb);
        h = 32'(sa % sb);
      end else begin
        l = a / b;
        h = a % b;
      end
    end else if (o[7]) begin
      p = sa * sb;
      {h, l} = 64'(p);
    end else if (o[6]) begin
      up = {32'd0, a} * {32'd0, b};
      {h, l} = up;
    end else if (o[1]) begin
      h = a;
    end else if (o[0]) begin
      l = a;
    end
  endfunction

  // Issue one op and hold it until the unit stops stalling, then let it retire
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    @(negedge clk);
    ex_valid = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
    stalls = 0;
    #1;
    while (stall && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0; op = 8'h00;
  endtask

  task automatic check_reads(input string nm, input logic [31:0] eh, input logic [31:0] el);
    ex_valid = 1'b1; op = 8'h04; #1;
    chk({nm, ".mflo"}, hilo_rdata, el);
    op = 8'h08; #1;
    chk({nm, ".mfhi"}, hilo_rdata, eh);
    op = 8'h00; #1;
    chk({nm, ".rdata_none"}, hilo_rdata, 32'd0);
    ex_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] m_hi, m_lo, sv_hi, sv_lo;
    bit is_div;

    vecs[0]  = '{"mult",      8'h80, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 0};
    vecs[1]  = '{"multu",     8'h40, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 0};
    vecs[2]  = '{"div_m7_2",  8'h20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{"divu_100_7",8'h10, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[4]  = '{"div_ovf",   8'h20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vecs[5]  = '{"div_dbz",   8'h20, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu_dbz",  8'h10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 33};
    vecs[7]  = '{"mthi",      8'h02, 32'hA5A5_A5A5, 32'd0,         32'hA5A5_A5A5, 32'hFFFF_FFFF, 0};
    vecs[8]  = '{"mtlo",      8'h01, 32'h5A5A_5A5A, 32'd0,         32'hA5A5_A5A5, 32'h5A5A_5A5A, 0};
    vecs[9]  = '{"prio_div",  8'hF3, 32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[10] = '{"prio_mult", 8'hC3, 32'd5,         32'd6,         32'd0,         32'd30,        0};
    vecs[11] = '{"prio_mthi", 8'h03, 32'h0000_0011, 32'd9,         32'h0000_0011, 32'd30,        0};
    vecs[12] = '{"div_7_m2",  8'h20, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};

    // Reset: outputs quiet even with a divide presented
    ex_valid = 1'b1; op = 8'h28; src_a = 32'd40; src_b = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    chk("rst.rdata", hilo_rdata, 32'd0);
    rst = 1'b0; ex_valid = 1'b0; op = 8'h00;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, st);
      chk({vecs[i].name, ".stalls"}, 32'(st), 32'(vecs[i].exp_stalls));
      chk({vecs[i].name, ".hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, ".lo"}, lo, vecs[i].exp_lo);
      check_reads(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Flush at RUN cnt=10: stall drops in-cycle, no write-back ever happens
    run_op(8'h02, 32'hCAFE_F00D, 32'd0, st);
    run_op(8'h01, 32'h0BAD_BEEF, 32'd0, st);
    @(negedge clk);
    ex_valid = 1'b1; op = 8'h10; src_a = 32'd9; src_b = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    chk("flush.stall_before", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    chk("flush.stall_same_cycle", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; op = 8'h00; #1;
    chk("flush.stall_after", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush.hi", hi, 32'hCAFE_F00D);
    chk("flush.lo", lo, 32'h0BAD_BEEF);
    run_op(8'h10, 32'd9, 32'd3, st);
    chk("flush.divu.stalls", 32'(st), 32'd33);
    chk("flush.divu.hi", hi, 32'd0);
    chk("flush.divu.lo", lo, 32'd3);

    // Flush together with a MULT issue
    run_op(8'h02, 32'h1357_9BDF, 32'd0, st);
    @(negedge clk);
    ex_valid = 1'b1; op = 8'h80; src_a = 32'd5; src_b = 32'd5; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; op = 8'h00;
    chk("flush_mult.hi", hi, 32'h1357_9BDF);
    chk("flush_mult.lo", lo, 32'd3);

    // Reset mid-divide
    @(negedge clk);
    ex_valid = 1'b1; op = 8'h20; src_a = 32'd50; src_b = 32'd5;
    repeat (6) @(negedge clk);
    rst = 1'b1; #1;
    chk("midrst.stall", {31'd0, stall}, 32'd0);
    chk("midrst.hi", hi, 32'd0);
    chk("midrst.lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; op = 8'h00;
    repeat (40) @(negedge clk);
    chk("midrst.hi_later", hi, 32'd0);
    chk("midrst.lo_later", lo, 32'd0);
    run_op(8'h10, 32'd9, 32'd3, st);
    chk("midrst.divu.stalls", 32'(st), 32'd33);
    chk("midrst.divu.hi", hi, 32'd0);
    chk("midrst.divu.lo", lo, 32'd3);

    // Randomized operations against the reference model
    m_hi = 32'd0; m_lo = 32'd3;
    for (int i = 0; i < 60; i++) begin
      logic [7:0]  o;
      logic [31:0] a, b;
      int k;
      k = int'($urandom_range(0, 5));
      case (k)
        0: o = 8'h80;
        1: o = 8'h40;
        2: o = 8'h20;
        3: o = 8'h10;
        4: o = 8'h02;
        default: o = 8'h01;
      endcase
      if ($urandom_range(0, 3) == 0) o = o | 8'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      sv_hi = m_hi; sv_lo = m_lo;
      ref_op(o, a, b, m_hi, m_lo, is_div);
      run_op(o, a, b, st);
      chk($sformatf("rnd%0d.op%h.stalls", i, o), 32'(st), is_div ? 32'd33 : 32'd0);
      chk($sformatf("rnd%0d.op%h.a%h.b%h.hi", i, o, a, b), hi, m_hi);
      chk($sformatf("rnd%0d.op%h.a%h.b%h.lo", i, o, a, b), lo, m_lo);
      if (i % 6 == 0) check_reads($sformatf("rnd%0d", i), m_hi, m_lo);
      if (sv_hi === m_hi && sv_lo === m_lo && i == 999) $display("unreachable");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
